sat_comb_diff: RTL and testbench
================================

# sat_comb_diff

Saturating fixed-point comb (differencing) stage: y[n] = x[n] − x[n−DEPTH] on a signed two's-complement stream, clamped to the representable range. It is the inverse partner of the saturating adder/integrator path. It sits after an integrator chain or at the decimated side of a CIC-style filter, and undoes accumulation with the same saturation rules. A sample is accepted per `in_valid`; the result is registered with one-cycle latency.

## Interface
- `size`, default 22: sample width in bits, signed two's complement.
- `DEPTH`, default 4: differential delay M in accepted samples, ≥1.
- `CNT_W`, default 16: width of the saturation event counter.
- `clk`  in  1  rising-edge clock; the only clock.
- `rst`  in  1  reset, synchronous, active-high.
- `clear`  in  1  synchronous flush of the delay line and fill state; counter kept.
- `in_valid`  in  1  `X` holds a sample this cycle.
- `X`  in  size  signed input sample.
- `out_valid`  out  1  `Y` holds a new result, one-cycle pulse per accepted sample.
- `Y`  out  size  signed saturated difference.
- `sat`  out  1  the `Y` currently presented was clamped; qualified by `out_valid`.
- `primed`  out  1  the delay line holds DEPTH real samples, so `Y` is a true difference.
- `sat_count`  out  CNT_W  number of clamped results since `rst`; sticks at all-ones.

## Operation
- The delay line is a DEPTH-entry shift register of size-bit words, initialised to zero. It advances only on accepted samples.
- Accept: `in_valid`=1 and `clear`=0.
  - Compute R = X − D, where D is the oldest delay-line entry.
  - Shift X into the line.
  - Register the result.
- Subtraction overflow:
  - Detected when X[msb] ≠ D[msb] and R[msb] ≠ X[msb].
  - Clamp on X ≥ 0: Y = +max = {0, (size−1){1}}, which is 0x1FFFFF at size=22.
  - Clamp on X < 0: Y = −min = {1, (size−1){0}}, which is 0x200000 at size=22.
- FSM, two states:
  - FILL: reset state. A fill counter counts accepted samples. After the DEPTH-th accept → RUN. `primed`=0. Outputs are still produced as X − 0, since the line is zero.
  - RUN: `primed`=1. Stays in RUN until `clear` or `rst`.
- `clear`=1 in either state:
  - zero the delay line and fill counter, go to FILL, drop any concurrent sample;
  - `out_valid`=0 next cycle;
  - `sat_count` is unchanged.
- `sat_count` increments on every clamped accept and saturates at 2^CNT_W − 1; it does not wrap.

## Timing
- Latency is 1 cycle: a sample accepted at edge k gives `Y`/`sat`/`out_valid` valid after edge k.
- Throughput is one sample per cycle. There is no backpressure; the downstream block must accept every `out_valid` pulse.
- `Y` and `sat` hold their last values while `out_valid`=0.
- `primed` rises in the same cycle as the `out_valid` of the DEPTH-th accepted sample. The first true difference is sample DEPTH+1.
- Reset (`rst`=1 at an edge), including mid-stream:
  - `Y`=0, `sat`=0, `out_valid`=0, `primed`=0, `sat_count`=0;
  - delay line zeroed, FSM in FILL.
- Precedence at an edge: `rst` > `clear` > `in_valid`.
- Gaps in `in_valid` do not age the delay line: the difference is between samples, not cycles.

## Structure
- Shared fixed-point package holds:
  - the `size` default;
  - the `SAT_POS(size)` and `SAT_NEG(size)` clamp constants, which the adder path also uses;
  - the FSM state encoding (FILL=0, RUN=1).
- One sub-module, `sat_sub`: combinational saturating subtract with ports A, B, D and a `sat` flag. It mirrors the saturating adder so that both share one clamp definition.
- The top level holds the delay line, fill counter, FSM, output registers and event counter.

## Test plan
- Reset, then DEPTH=4, feed 10,20,30,40,50,60 → `Y` = 10,20,30,40,40,40. `primed` rises with the 4th result. `sat`=0 throughout.
- Prime with four 0x200000 samples, then feed 0x1FFFFF. True difference 0x1FFFFF − 0x200000 = +4194303 is outside the range → `Y`=0x1FFFFF, `sat`=1, `sat_count`=1.
- Prime with four 0x1FFFFF samples, then feed 0x200000 → `Y`=0x200000, `sat`=1, `sat_count` increments.
- Irregular `in_valid` (gaps of 0–3 cycles) over a ramp of step 5 → every `Y` after priming = 20 (4 samples × 5). `out_valid` appears exactly one cycle after each accept.
- Assert `clear` together with `in_valid` while in RUN:
  - → that sample is dropped, `primed`=0, `out_valid`=0;
  - the next 4 outputs equal the raw X;
  - `sat_count` is preserved.
- Set CNT_W=2 and force 5 clamped results → `sat_count` stops at 3. Then assert `rst` mid-stream → all outputs 0 at the next cycle.

Source files
------------

// File: rtl/sat_comb_diff_pkg.sv
// Shared fixed-point definitions for the saturating adder/comb datapath:
// default sample width, clamp constants and comb FSM encoding.
package sat_comb_diff_pkg;

    localparam int SIZE_DEFAULT = 22;

    // Comb fill-state FSM encoding
    localparam logic [0:0] ST_FILL = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Most positive w-bit two's-complement value, returned zero-extended
    function automatic logic [63:0] SAT_POS(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    // Most negative w-bit two's-complement value (low w bits are significant)
    function automatic logic [63:0] SAT_NEG(input int w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/sat_comb_diff_if.sv
// Sample stream bundle for the comb stage: input sample strobe plus the
// registered, saturated result strobe.
interface sat_comb_diff_if #(parameter int size = 22);

    logic            in_valid;
    logic [size-1:0] X;
    logic            out_valid;
    logic [size-1:0] Y;
    logic            sat;

    modport master (
        output in_valid,
        output X,
        input  out_valid,
        input  Y,
        input  sat
    );

    modport slave (
        input  in_valid,
        input  X,
        output out_valid,
        output Y,
        output sat
    );

endinterface

// File: rtl/sat_comb_diff_sat_sub.sv
// Combinational saturating subtract D = A - B, clamped with the same
// constants as the saturating adder.
module sat_sub
    import sat_comb_diff_pkg::*;
#(
    parameter int size = SIZE_DEFAULT
) (
    input  logic [size-1:0] A,
    input  logic [size-1:0] B,
    output logic [size-1:0] D,
    output logic            sat
);

    localparam logic [size-1:0] POS_C = size'(SAT_POS(size));
    localparam logic [size-1:0] NEG_C = size'(SAT_NEG(size));

    logic [size-1:0] raw_s;
    logic            ovf_s;

    // Wrapping difference; overflow only when operand signs differ and the
    // result sign disagrees with the minuend.
    always_comb begin
        raw_s = A - B;
        ovf_s = (A[size-1] != B[size-1]) && (raw_s[size-1] != A[size-1]);
        if (ovf_s) begin
            sat = 1'b1;
            if (A[size-1]) begin
                D = NEG_C;
            end else begin
                D = POS_C;
            end
        end else begin
            sat = 1'b0;
            D   = raw_s;
        end
    end

endmodule

// File: rtl/sat_comb_diff.sv
// Saturating comb stage y[n] = x[n] - x[n-DEPTH] with a fill-state FSM,
// one-cycle registered output and a sticky saturation event counter.
module sat_comb_diff
    import sat_comb_diff_pkg::*;
#(
    parameter int size  = SIZE_DEFAULT,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    sat_comb_diff_if.slave   bus,
    output logic             primed,
    output logic [CNT_W-1:0] sat_count
);

    localparam int FILL_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(DEPTH - 1);

    logic [size-1:0]   line_r [DEPTH];
    logic [FILL_W-1:0] fill_cnt_r;
    logic [0:0]        state_r;
    logic [size-1:0]   y_r;
    logic              sat_r;
    logic              out_valid_r;
    logic [CNT_W-1:0]  sat_count_r;

    logic              accept_s;
    logic [size-1:0]   diff_s;
    logic              clamp_s;
    logic [0:0]        state_nx_s;
    logic [FILL_W-1:0] fill_nx_s;

    assign accept_s = bus.in_valid & ~clear;

    sat_sub #(.size(size)) u_sub (
        .A   (bus.X),
        .B   (line_r[DEPTH-1]),
        .D   (diff_s),
        .sat (clamp_s)
    );

    // Fill-state sequencing; clear and rst override this in the register block
    always_comb begin
        state_nx_s = state_r;
        fill_nx_s  = fill_cnt_r;
        case (state_r)
            ST_FILL: begin
                if (accept_s) begin
                    if (fill_cnt_r == FILL_LAST) begin
                        state_nx_s = ST_RUN;
                        fill_nx_s  = {FILL_W{1'b0}};
                    end else begin
                        fill_nx_s  = fill_cnt_r + FILL_W'(1);
                    end
                end else begin
                    fill_nx_s  = fill_cnt_r;
                end
            end
            ST_RUN: begin
                state_nx_s = ST_RUN;
            end
            default: begin
                state_nx_s = ST_FILL;
                fill_nx_s  = {FILL_W{1'b0}};
            end
        endcase
    end

    // FSM, delay line and result registers; rst beats clear beats a sample
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_FILL;
            fill_cnt_r  <= {FILL_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                line_r[i] <= {size{1'b0}};
            end
            y_r         <= {size{1'b0}};
            sat_r       <= 1'b0;
            out_valid_r <= 1'b0;
        end else if (clear) begin
            state_r     <= ST_FILL;
            fill_cnt_r  <= {FILL_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                line_r[i] <= {size{1'b0}};
            end
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            fill_cnt_r  <= fill_nx_s;
            out_valid_r <= accept_s;
            if (accept_s) begin
                for (int i = 1; i < DEPTH; i++) begin
                    line_r[i] <= line_r[i-1];
                end
                line_r[0] <= bus.X;
                y_r       <= diff_s;
                sat_r     <= clamp_s;
            end
        end
    end

    // Clamp event counter survives clear and sticks at all-ones
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_count_r <= {CNT_W{1'b0}};
        end else if (accept_s && clamp_s && (sat_count_r != {CNT_W{1'b1}})) begin
            sat_count_r <= sat_count_r + CNT_W'(1);
        end
    end

    assign bus.out_valid = out_valid_r;
    assign bus.Y         = y_r;
    assign bus.sat       = sat_r;
    assign primed        = (state_r == ST_RUN);
    assign sat_count     = sat_count_r;

endmodule

// File: tb/tb_sat_comb_diff.sv
// Scoreboard bench for sat_comb_diff: a history-queue reference model predicts
// each result; a monitor compares DUT outputs one cycle after each edge.
module tb_sat_comb_diff;

    localparam int W     = 22;
    localparam int DEPTH = 4;
    localparam longint LIM_HI = 64'sd2097151;
    localparam longint LIM_LO = -64'sd2097152;

    typedef struct {
        logic [W-1:0] y;
        logic         sat;
        logic         primed;
        int           cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clear = 1'b0;
    logic        primed, primed2;
    logic [15:0] sat_count;
    logic [1:0]  sat_count2;

    sat_comb_diff_if #(.size(W)) bus ();
    sat_comb_diff_if #(.size(W)) bus2 ();

    assign bus2.in_valid = bus.in_valid;
    assign bus2.X        = bus.X;

    sat_comb_diff #(.size(W), .DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .clear(clear), .bus(bus),
        .primed(primed), .sat_count(sat_count)
    );

    sat_comb_diff #(.size(W), .DEPTH(DEPTH), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .clear(clear), .bus(bus2),
        .primed(primed2), .sat_count(sat_count2)
    );

    always #5 clk = ~clk;

    exp_t         q[$];
    longint       hist[$];
    int           m_cnt = 0;
    logic [W-1:0] hold_y = '0;
    logic         hold_sat = 1'b0;
    logic         m_primed = 1'b0;
    bit           mon_en = 1'b0;
    int           total = 0;
    int           bad = 0;

    function automatic int cap3(input int c);
        return (c > 3) ? 3 : c;
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs and advance the reference model for that edge
    task automatic cyc(input logic r, input logic c, input logic v, input logic [W-1:0] x);
        longint xs, d, diff;
        exp_t   e;
        @(negedge clk);
        rst = r; clear = c; bus.in_valid = v; bus.X = x;
        if (r) begin
            hist.delete(); m_cnt = 0; hold_y = '0; hold_sat = 1'b0; m_primed = 1'b0;
        end else if (c) begin
            hist.delete(); m_primed = 1'b0;
        end else if (v) begin
            xs = $signed(x);
            d  = (hist.size() >= DEPTH) ? hist[hist.size() - DEPTH] : 64'sd0;
            diff = xs - d;
            e.sat = 1'b0;
            if (diff > LIM_HI) begin diff = LIM_HI; e.sat = 1'b1; end
            if (diff < LIM_LO) begin diff = LIM_LO; e.sat = 1'b1; end
            if (e.sat) m_cnt++;
            hist.push_back(xs);
            m_primed = (hist.size() >= DEPTH);
            e.y = diff[W-1:0];
            e.primed = m_primed;
            e.cnt = m_cnt;
            hold_y = e.y; hold_sat = e.sat;
            q.push_back(e);
        end
    endtask

    // Monitor: one sample point per cycle, just after the active edge
    initial begin
        exp_t e;
        bit   exp_v;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                exp_v = (q.size() != 0);
                chk("out_valid", bus.out_valid, exp_v);
                chk("out_valid_cnt2", bus2.out_valid, exp_v);
                if (exp_v) begin
                    e = q.pop_front();
                    chk("Y", bus.Y, e.y);
                    chk("sat", bus.sat, e.sat);
                    chk("primed", primed, e.primed);
                    chk("sat_count", sat_count, e.cnt);
                    chk("Y_cnt2", bus2.Y, e.y);
                    chk("sat_count_cnt2", sat_count2, cap3(e.cnt));
                end else begin
                    chk("Y_hold", bus.Y, hold_y);
                    chk("sat_hold", bus.sat, hold_sat);
                    chk("primed_idle", primed, m_primed);
                    chk("primed_idle_cnt2", primed2, m_primed);
                    chk("sat_count_idle", sat_count, m_cnt);
                    chk("sat_count_idle_cnt2", sat_count2, cap3(m_cnt));
                end
            end
        end
    end

    initial begin
        logic [W-1:0] val;
        bus.in_valid = 1'b0;
        bus.X = '0;

        cyc(1'b1, 1'b0, 1'b0, '0);
        mon_en = 1'b1;
        cyc(1'b1, 1'b0, 1'b1, 22'd99);
        cyc(1'b0, 1'b0, 1'b0, '0);

        // Basic ramp through fill into run
        for (int i = 1; i <= 6; i++) cyc(1'b0, 1'b0, 1'b1, W'(10 * i));
        cyc(1'b0, 1'b0, 1'b0, '0);

        // Positive clamp
        cyc(1'b0, 1'b1, 1'b0, '0);
        repeat (4) cyc(1'b0, 1'b0, 1'b1, 22'h200000);
        cyc(1'b0, 1'b0, 1'b1, 22'h1FFFFF);
        cyc(1'b0, 1'b0, 1'b0, '0);

        // Negative clamp
        cyc(1'b0, 1'b1, 1'b0, '0);
        repeat (4) cyc(1'b0, 1'b0, 1'b1, 22'h1FFFFF);
        cyc(1'b0, 1'b0, 1'b1, 22'h200000);

        // Ramp with irregular gaps
        cyc(1'b0, 1'b1, 1'b0, '0);
        val = 22'd100;
        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(0, 3)) cyc(1'b0, 1'b0, 1'b0, W'($urandom));
            cyc(1'b0, 1'b0, 1'b1, val);
            val = val + 22'd5;
        end

        // Clear with a concurrent sample while running
        cyc(1'b0, 1'b1, 1'b1, 22'd777);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b1, W'($urandom_range(0, 5000)));

        // Several clamps to saturate the narrow counter
        cyc(1'b0, 1'b1, 1'b0, '0);
        repeat (4) cyc(1'b0, 1'b0, 1'b1, 22'h200000);
        repeat (4) cyc(1'b0, 1'b0, 1'b1, 22'h1FFFFF);

        // Random traffic with extremes, occasional clear and reset
        for (int i = 0; i < 400; i++) begin
            int   sel;
            logic [W-1:0] x;
            sel = $urandom_range(0, 3);
            x = (sel == 0) ? 22'h1FFFFF : (sel == 1) ? 22'h200000 : W'($urandom);
            cyc(($urandom_range(0, 149) == 0), ($urandom_range(0, 29) == 0),
                ($urandom_range(0, 3) != 0), x);
        end

        // Reset mid-stream
        repeat (6) cyc(1'b0, 1'b0, 1'b1, 22'h1FFFFF);
        cyc(1'b1, 1'b0, 1'b1, 22'h200000);
        cyc(1'b0, 1'b0, 1'b0, '0);
        cyc(1'b0, 1'b0, 1'b0, '0);

        @(posedge clk);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
